// File: rtl/gray_step_source.sv
// Debounced pushbutton step source driving a 4-bit binary/Gray counter.
// Optional free-running auto-step is compiled in when AUTO_STEP_EN is defined.
module gray_step_source #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_PERIOD     = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_step,
  input  logic       dir,
  input  logic       clr,
  input  logic       auto_en,
  output logic [3:0] gray,
  output logic [3:0] bin,
  output logic       step_pulse
);

  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  btn_sync, dir_sync, clr_sync, auto_sync;
  logic        btn_s, dir_s, clr_s, auto_s;
  logic [19:0] db_cnt;
  logic        btn_stable, btn_stable_d;
  logic        btn_req, auto_req, step_req;
  logic [3:0]  bin_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync  <= 2'b00;
      dir_sync  <= 2'b00;
      clr_sync  <= 2'b00;
      auto_sync <= 2'b00;
    end else begin
      btn_sync  <= {btn_sync[0], btn_step};
      dir_sync  <= {dir_sync[0], dir};
      clr_sync  <= {clr_sync[0], clr};
      auto_sync <= {auto_sync[0], auto_en};
    end
  end

  assign btn_s  = btn_sync[1];
  assign dir_s  = dir_sync[1];
  assign clr_s  = clr_sync[1];
  assign auto_s = auto_sync[1];

  // Debounce keeps running during clr so a press accepted then is simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt       <= '0;
      btn_stable   <= 1'b0;
      btn_stable_d <= 1'b0;
    end else begin
      btn_stable_d <= btn_stable;
      if (btn_s == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt     <= '0;
        btn_stable <= ~btn_stable;
      end else begin
        db_cnt <= db_cnt + 20'd1;
      end
    end
  end

  assign btn_req = btn_stable & ~btn_stable_d;

`ifdef AUTO_STEP_EN
  localparam logic [25:0] AUTO_LAST = 26'(AUTO_PERIOD - 1);
  logic [25:0] auto_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (!auto_s || clr_s || auto_cnt == AUTO_LAST) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 26'd1;
    end
  end

  assign auto_req = auto_s & ~clr_s & (auto_cnt == AUTO_LAST);
`else
  assign auto_req = 1'b0;
`endif

  // Button and auto requests in the same cycle collapse into one step.
  assign step_req = btn_req | auto_req;
  assign bin_next = dir_s ? (bin - 4'd1) : (bin + 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin        <= 4'd0;
      gray       <= 4'd0;
      step_pulse <= 1'b0;
    end else if (clr_s) begin
      bin        <= 4'd0;
      gray       <= 4'd0;
      step_pulse <= 1'b0;
    end else if (step_req) begin
      bin        <= bin_next;
      gray       <= bin_next ^ (bin_next >> 1);
      step_pulse <= 1'b1;
    end else begin
      step_pulse <= 1'b0;
    end
  end

endmodule
